// File: rtl/hs_rx_pkg.sv
// hs_rx_pkg: shared types and constants for the data handshake responder and its synchronizer
package hs_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;
  localparam logic   ACK_RST   = 1'b0;
  localparam logic   VALID_RST = 1'b0;
  localparam logic   SYNC_RST  = 1'b0;
  localparam state_t STATE_RST = IDLE;
  localparam int     SYNC_MIN  = 2;
  localparam int     SYNC_MAX  = 4;
endpackage

// File: rtl/sync_nff.sv
// sync_nff: single-bit level synchronizer, STAGES flops deep
// Ports: clk, rst (async, active high), d_i (async level in), q_o (synchronized level out)
module sync_nff
  import hs_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] chain_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) chain_q <= {STAGES{SYNC_RST}};
    else     chain_q <= {chain_q[STAGES-2:0], d_i};
  assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/hs_data_responder.sv
// hs_data_responder: receive side of a 4-phase req/ack data handshake, delivering words on valid/ready
// Ports: clk, rst (async, active high); req_async/data_async from the remote initiator;
//        ack level back to the initiator; out_data/out_valid/out_ready local stream;
//        busy (not IDLE); xfer_cnt (completed transfers, wrapping)
module hs_data_responder
  import hs_rx_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_async,
  input  logic [DW-1:0] data_async,
  output logic          ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [CW-1:0] xfer_cnt
);
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("hs_data_responder: SYNC_STAGES out of range");
  end
  logic          req_s;
  state_t        state_q;
  logic          ack_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] xfer_cnt_q;
  sync_nff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_async),
    .q_o (req_s)
  );
  // data_async is only sampled once req_s is high, when the initiator guarantees it is stable
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= STATE_RST;
      ack_q       <= ACK_RST;
      out_valid_q <= VALID_RST;
      out_data_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (req_s) begin
            out_data_q  <= data_async;
            out_valid_q <= 1'b1;
            state_q     <= VALID;
          end
        VALID:
          if (out_ready) begin
            out_valid_q <= 1'b0;
            ack_q       <= 1'b1;
            xfer_cnt_q  <= xfer_cnt_q + 1'b1;
            state_q     <= ACK;
          end
        ACK:
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        default: begin
          ack_q       <= ACK_RST;
          out_valid_q <= VALID_RST;
          out_data_q  <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign busy      = state_q != IDLE;
endmodule

// File: doc/hs_data_responder.md
Name: hs_data_responder

Overview:
- Receive-side responder of a 4-phase req/ack data handshake.
- Sits in the destination clock domain. It synchronizes an asynchronous request from a remote initiator and captures that initiator's held data bus.
- It presents the captured data on a local valid/ready interface, then returns a level acknowledge that the initiator synchronizes back into its own domain.
- It is the data-carrying responder counterpart to the team's pulse handshake initiator.

Parameters:
- DW, 8, width of transferred data word
- SYNC_STAGES, 2, flops in req synchronizer chain (legal 2..4)
- CW, 8, width of transfer counter

Ports:
- clk  in  1  destination-domain clock
- rst  in  1  asynchronous, active-high reset
- req_async  in  1  request level from remote domain, unsynchronized
- data_async  in  DW  data from remote domain; initiator holds it stable while req high
- ack  out  1  acknowledge level to remote domain, driven directly from a flop
- out_data  out  DW  captured word
- out_valid  out  1  captured word available
- out_ready  in  1  local consumer accepts word
- busy  out  1  high in any state other than IDLE
- xfer_cnt  out  CW  completed-transfer count

Behaviour:
- Reset: rst asserted asynchronously forces the following.
  - ack=0, out_valid=0, out_data=0, busy=0, xfer_cnt=0.
  - Sync chain cleared; state=IDLE.
- Sync chain: req_s = req_async delayed through SYNC_STAGES flops on clk. The FSM uses only req_s. data_async is never synchronized; it is sampled only when req_s=1, which the protocol guarantees is stable.
- FSM states and transitions:
  - IDLE: when req_s=1, out_data<=data_async, out_valid<=1, go VALID.
  - VALID: out_valid held high and out_data held stable. On clk with out_valid&out_ready, out_valid<=0, ack<=1, xfer_cnt<=xfer_cnt+1, go ACK. No timeout; backpressure stalls indefinitely, and the initiator stays blocked because ack stays low.
  - ACK: ack held 1. When req_s=0, ack<=0, go IDLE.
- Latency:
  - req_async rise to out_valid high: SYNC_STAGES+1 clk edges.
  - Accept edge to ack high: same edge, because ack is registered on the accept cycle.
  - req_s low to ack low: 1 edge.
- out_ready is ignored when out_valid=0. out_ready high and waiting in advance gives acceptance on the first cycle out_valid is high, i.e. out_valid is high for exactly 1 cycle.
- Back-to-back transfers: IDLE is reached only after req_s is seen low, so one req high phase yields exactly one word.
  - A new req rise may occur any time after the initiator sees ack low.
  - The minimum responder cycle is (SYNC_STAGES+1) + 1 + (SYNC_STAGES+1) edges plus the initiator's round trip.
- xfer_cnt wraps from 2^CW-1 to 0 silently.
- Reset mid-operation: any state returns to IDLE with ack=0. If req_async is still high after rst releases, the word is re-captured after SYNC_STAGES+1 edges. This duplicate is accepted behaviour; the initiator must be reset alongside.
- Protocol violation: req_async dropping while in VALID is not detected. The captured word is still delivered, and the FSM then passes through ACK with ack high for 1 cycle.
- Illegal state encodings recover to IDLE with outputs cleared.

Decomposition:
- Package hs_rx_pkg:
  - state enum {IDLE, VALID, ACK}, 2-bit encoding.
  - Reset-value constants.
  - Legal SYNC_STAGES range constants, checked at elaboration.
- Sub-module sync_nff (parameter STAGES, 1-bit, clk/rst async high) for the req chain. It is reusable for other single-bit level synchronizers in the codebase.
- FSM, capture register and counter stay in the top module.

Test Plan:
- Reset with req_async=1: hold rst 3 cycles and release. ack=0, out_valid=0 during rst. out_valid rises on the 3rd edge after release (SYNC_STAGES=2) with out_data=data_async.
- Single transfer, DW=8, data_async=8'hA5, out_ready tied 1: out_valid high exactly 1 cycle with 8'hA5; ack rises on the same edge out_valid falls. Dropping req gives ack=0 3 edges later. xfer_cnt=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_valid and out_data=8'h3C held for 10 cycles and ack stays 0. out_ready=1 gives ack=1 on the next edge.
- Ten back-to-back transfers 8'h00..8'h09 by a model initiator in an unrelated clock (ratio 1:2.7): exactly 10 words in order, no duplicates, xfer_cnt=10.
- Counter wrap, CW=4: 17 transfers -> xfer_cnt=1.
- Mid-operation reset pulsed while in ACK: ack=0 asynchronously, state IDLE. req still high gives one duplicate capture. Afterwards, normal completion resumes.
